// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, single-outstanding imem request/valid handshake,
// prefetch FIFO feeding the F/D buffer. Define FETCH_RESET_VECTOR_EN to boot from {M[0], M[1]}.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction_out,
  output logic [31:0] PC_out,
  output logic        out_valid
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic [2:0] {IDLE, WAIT, DROP, VEC_HI, VEC_HI_W, VEC_LO, VEC_LO_W} state_t;
  localparam state_t START = VEC_HI;
`else
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  localparam state_t START = IDLE;
`endif

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [15:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          redirect;
  logic          push;
  logic          pop;

`ifdef FETCH_RESET_VECTOR_EN
  logic [15:0] vec_hi;
  // Redirects are meaningless until the boot vector has been loaded.
  assign redirect = branch_taken && (state inside {IDLE, WAIT, DROP});
`else
  assign redirect = branch_taken;
`endif

  // Handshake: imem_req is a one-cycle strobe accepted on the edge that raised it;
  // exactly one imem_valid pulse answers each request, and it is never back-pressured.
  assign push = (state == WAIT) && imem_valid && !redirect;
  assign pop  = (count != '0) && !stall && !redirect;

  assign out_valid       = (count != '0);
  assign instruction_out = out_valid ? fifo_instr[rd_ptr] : 16'h0000;
  assign PC_out          = out_valid ? fifo_pc[rd_ptr] : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]    <= imem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0000_0000;
`ifdef FETCH_RESET_VECTOR_EN
      vec_hi    <= 16'h0000;
`endif
    end else begin
      imem_req <= 1'b0;
      case (state)
        // Nothing is outstanding in IDLE, so count alone decides whether a word fits.
        IDLE: if (!redirect && count < FULL) begin
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
          state     <= WAIT;
        end
        WAIT: begin
          if (redirect) begin
            state <= imem_valid ? IDLE : DROP;
          end else if (imem_valid) begin
            fetch_pc <= fetch_pc + 32'd1;
            state    <= IDLE;
          end
        end
        DROP: if (imem_valid) state <= IDLE;
`ifdef FETCH_RESET_VECTOR_EN
        VEC_HI: begin
          imem_req  <= 1'b1;
          imem_addr <= 32'h0000_0000;
          state     <= VEC_HI_W;
        end
        VEC_HI_W: if (imem_valid) begin
          vec_hi <= imem_data;
          state  <= VEC_LO;
        end
        VEC_LO: begin
          imem_req  <= 1'b1;
          imem_addr <= 32'h0000_0001;
          state     <= VEC_LO_W;
        end
        VEC_LO_W: if (imem_valid) begin
          fetch_pc <= {vec_hi, imem_data};
          state    <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
      if (redirect) fetch_pc <= branch_target;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable memory model, expected-queue
// scoreboard on F/D pops, and one task per scenario.
module tb_fetch_unit;
  localparam int DEPTH = 2;
`ifdef FETCH_RESET_VECTOR_EN
  localparam logic [31:0] BOOT_PC = 32'h0000_0100;
`else
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic [15:0] instruction_out;
  logic [31:0] PC_out;
  logic        out_valid;

  int          checks = 0;
  int          failures = 0;
  logic [47:0] exp_q[$];
  logic [31:0] req_log[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = 32'h0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instruction_out(instruction_out), .PC_out(PC_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
`ifdef FETCH_RESET_VECTOR_EN
    if (a == 32'h0) return 16'h0000;
    if (a == 32'h1) return 16'h0100;
`endif
    if (a < 32'd4) return 16'hA001 + a[15:0];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Memory: a request seen after an edge is answered lat cycles after its issue edge.
  always begin
    @(posedge clk); #1;
    imem_valid = 1'b0;
    if (!rst_n) begin
      mem_cnt = 0;
    end else begin
      if (imem_req) begin
        mem_cnt    = lat;
        mem_addr_q = imem_addr;
        req_log.push_back(imem_addr);
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem_word(mem_addr_q);
        end
      end
    end
  end

  // Scoreboard: every F/D pop must match the head of the expected queue.
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst_n && out_valid && !stall && !branch_taken) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop got instr=%h pc=%h, required no pop", instruction_out, PC_out);
      end else begin
        e = exp_q.pop_front();
        if ({instruction_out, PC_out} !== e) begin
          failures++;
          $display("FAIL pop_data got instr=%h pc=%h, required instr=%h pc=%h",
                   instruction_out, PC_out, e[47:32], e[31:0]);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic expect_word(input logic [31:0] a);
    exp_q.push_back({mem_word(a), a});
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    stall = 1'b1;
    exp_q.delete();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    @(posedge clk); #2;
    branch_taken  = 1'b1;
    branch_target = t;
    @(posedge clk); #2;
    branch_taken  = 1'b0;
  endtask

  task automatic test_reset;
    bit seen;
    stall = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b required 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b required 0", out_valid); end
    checks++; if (instruction_out !== 16'h0) begin failures++; $display("FAIL rst_instr got %h required 0000", instruction_out); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL rst_pc got %h required 0", PC_out); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h required 0", imem_addr); end
    req_log.delete();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #2;
`ifdef FETCH_RESET_VECTOR_EN
      if (req_log.size() >= 3) seen = 1'b1;
`else
      if (req_log.size() >= 1) seen = 1'b1;
`endif
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL first_req got %0d requests, required first request within 30 cycles", req_log.size());
    end else begin
      checks++; if (req_log[0] !== 32'h0) begin failures++; $display("FAIL first_addr got %h required 0", req_log[0]); end
`ifdef FETCH_RESET_VECTOR_EN
      checks++; if (req_log[1] !== 32'h1) begin failures++; $display("FAIL vec_lo_addr got %h required 1", req_log[1]); end
      checks++; if (req_log[2] !== 32'h100) begin failures++; $display("FAIL boot_addr got %h required 00000100", req_log[2]); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec_hidden got out_valid=%b required 0", out_valid); end
`endif
    end
  endtask

  task automatic test_stream;
    bit ok;
    lat = 1;
    redirect_to(32'h0);
    for (int a = 0; a < 4; a++) expect_word(a);
    pop_cyc.delete();
    stall = 1'b0;
    drain(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stream_drain got %0d pops, required 4", pop_cyc.size()); end
    checks++; if (pop_cyc.size() != 4) begin failures++; $display("FAIL stream_count got %0d required 4", pop_cyc.size()); end
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++) begin
      checks++;
      if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
        failures++; $display("FAIL stream_rate got %0d cycles required 2", pop_cyc[i] - pop_cyc[i-1]);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    bit req_seen;
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i >= 4 && imem_req) req_seen = 1'b1;
    end
    checks++; if (req_seen) begin failures++; $display("FAIL full_req got 1 required 0"); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid got %b required 1", out_valid); end
    checks++; if (PC_out !== 32'h4) begin failures++; $display("FAIL full_head_pc got %h required 4", PC_out); end
    checks++; if (instruction_out !== mem_word(32'h4)) begin failures++; $display("FAIL full_head_instr got %h required %h", instruction_out, mem_word(32'h4)); end
    for (int a = 4; a < 8; a++) expect_word(a);
    stall = 1'b0;
    drain(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_release_drain got pending words, required 0"); end
  endtask

  task automatic test_redirect;
    bit ok;
    bit found;
    lat = 3;
    stall = 1'b1;
    redirect_to(32'h20);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_req && out_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL redir_setup got no WAIT with queued word, required one"); end
    req_log.delete();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    @(posedge clk); #2;
    branch_taken  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got out_valid=%b required 0", out_valid); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL redir_flush_pc got %h required 0", PC_out); end
    expect_word(32'h40);
    expect_word(32'h41);
    stall = 1'b0;
    drain(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL redir_drain got pending words, required 0"); end
    checks++;
    if (req_log.size() == 0 || req_log[0] !== 32'h40) begin
      failures++; $display("FAIL redir_addr got %h required 00000040", (req_log.size() > 0) ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    lat = 1;
    stall = 1'b1;
    redirect_to(32'hFFFF_FFFF);
    req_log.delete();
    expect_word(32'hFFFF_FFFF);
    expect_word(32'h0);
    stall = 1'b0;
    drain(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain got pending words, required 0"); end
    checks++;
    if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFF || req_log[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_addr got %0d requests, required FFFFFFFF then 00000000", req_log.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    stall = 1'b1;
    @(posedge clk); #2;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    @(posedge clk); #2;
    branch_target = 32'h200;
    @(posedge clk); #2;
    branch_taken  = 1'b0;
    expect_word(32'h200);
    expect_word(32'h201);
    stall = 1'b0;
    drain(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_drain got pending words, required 0"); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    lat = 3;
    stall = 1'b1;
    redirect_to(32'h300);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #2;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got %b required 0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL async_rst_req got %b required 0", imem_req); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL async_rst_pc got %h required 0", PC_out); end
    repeat (2) @(posedge clk);
    req_log.delete();
    @(negedge clk) rst_n = 1'b1;
    expect_word(BOOT_PC);
    expect_word(BOOT_PC + 32'd1);
    stall = 1'b0;
    drain(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_rst_drain got pending words, required 0"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
